// File: rtl/program_loader.sv
// Program loader: takes a framed image from a byte stream, writes the payload
// to program memory and releases the CPU from reset once the checksum matches.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for the sync byte, everything else is discarded
// S_LEN_LO  | frame started, waiting for the low length byte
// S_LEN_HI  | waiting for the high length byte, then length is validated
// S_PAYLOAD | writing payload bytes to consecutive addresses
// S_CHECK   | waiting for the checksum byte
// S_DONE    | image loaded, CPU released; terminal until reset
// S_ERROR   | last frame failed; a new sync byte starts a retry
module program_loader #(
    parameter logic [31:0] BASE_ADDR      = 32'h0,
    parameter int unsigned MAX_BYTES      = 1024,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic [31:0] write_address,
    output logic [7:0]  write_data,
    output logic        write_enable,
    output logic        cpu_reset_n,
    output logic        load_done,
    output logic        load_error,
    output logic [15:0] byte_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_PAYLOAD,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [15:0] MAX_LEN = 16'(MAX_BYTES);

    state_t      state_q, state_d;
    logic [7:0]  len_lo_q, len_lo_d;
    logic [15:0] len_q, len_d;
    logic [15:0] count_q, count_d;
    logic [7:0]  csum_q, csum_d;
    logic [31:0] timer_q, timer_d;
    logic        rx_ready_q, rx_ready_d;
    logic [31:0] write_address_q, write_address_d;
    logic [7:0]  write_data_q, write_data_d;
    logic        write_enable_q, write_enable_d;
    logic        cpu_reset_n_q, cpu_reset_n_d;
    logic        load_done_q, load_done_d;
    logic        load_error_q, load_error_d;
    logic [15:0] byte_count_q, byte_count_d;

    logic        hs;
    logic        timed;
    logic [15:0] len_new;

    assign rx_ready      = rx_ready_q;
    assign write_address = write_address_q;
    assign write_data    = write_data_q;
    assign write_enable  = write_enable_q;
    assign cpu_reset_n   = cpu_reset_n_q;
    assign load_done     = load_done_q;
    assign load_error    = load_error_q;
    assign byte_count    = byte_count_q;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d         = state_q;
        len_lo_d        = len_lo_q;
        len_d           = len_q;
        count_d         = count_q;
        csum_d          = csum_q;
        timer_d         = TIMEOUT_CYCLES;
        write_address_d = write_address_q;
        write_data_d    = write_data_q;
        write_enable_d  = 1'b0;
        byte_count_d    = byte_count_q;
        len_new         = {rx_data, len_lo_q};

        hs    = rx_valid & rx_ready_q;
        timed = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                (state_q == S_PAYLOAD) || (state_q == S_CHECK);

        case (state_q)
            S_IDLE, S_ERROR: begin
                if (hs && rx_data == SYNC_BYTE) begin
                    state_d      = S_LEN_LO;
                    count_d      = 16'h0;
                    csum_d       = 8'h0;
                    byte_count_d = 16'h0;
                end
            end
            S_LEN_LO: begin
                if (hs) begin
                    len_lo_d = rx_data;
                    state_d  = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (hs) begin
                    len_d = len_new;
                    if (len_new == 16'h0 || len_new > MAX_LEN) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (hs) begin
                    write_address_d = BASE_ADDR + {16'h0, count_q};
                    write_data_d    = rx_data;
                    write_enable_d  = 1'b1;
                    count_d         = count_q + 16'd1;
                    csum_d          = csum_q + rx_data;
                    byte_count_d    = count_q + 16'd1;
                    if (count_q == len_q - 16'd1) begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (hs) begin
                    state_d = (rx_data == csum_q) ? S_DONE : S_ERROR;
                end
            end
            default: begin
            end
        endcase

        // Idle timer counts down between handshakes; a handshake or any
        // untimed state reloads it, so only a silent gap can expire it.
        if (timed && !hs) begin
            timer_d = timer_q - 32'd1;
            if (timer_q <= 32'd1) begin
                state_d = S_ERROR;
            end
        end

        rx_ready_d    = (state_d != S_DONE);
        cpu_reset_n_d = (state_d == S_DONE);
        load_done_d   = (state_d == S_DONE);
        load_error_d  = (state_d == S_ERROR);
    end

    // State and output registers; reset aborts any frame immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= S_IDLE;
            len_lo_q        <= 8'h0;
            len_q           <= 16'h0;
            count_q         <= 16'h0;
            csum_q          <= 8'h0;
            timer_q         <= 32'h0;
            rx_ready_q      <= 1'b0;
            write_address_q <= 32'h0;
            write_data_q    <= 8'h0;
            write_enable_q  <= 1'b0;
            cpu_reset_n_q   <= 1'b0;
            load_done_q     <= 1'b0;
            load_error_q    <= 1'b0;
            byte_count_q    <= 16'h0;
        end else begin
            state_q         <= state_d;
            len_lo_q        <= len_lo_d;
            len_q           <= len_d;
            count_q         <= count_d;
            csum_q          <= csum_d;
            timer_q         <= timer_d;
            rx_ready_q      <= rx_ready_d;
            write_address_q <= write_address_d;
            write_data_q    <= write_data_d;
            write_enable_q  <= write_enable_d;
            cpu_reset_n_q   <= cpu_reset_n_d;
            load_done_q     <= load_done_d;
            load_error_q    <= load_error_d;
            byte_count_q    <= byte_count_d;
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader: frames are driven byte by byte, expected
// memory writes go into a scoreboard queue and a monitor compares every
// write strobe against it; frame outcomes come from a simple frame model.
module tb_program_loader;

    localparam logic [31:0] BASE = 32'h0;
    localparam int          MAX  = 1024;
    localparam int          TMO  = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h0;
    logic        rx_ready;
    logic [31:0] write_address;
    logic [7:0]  write_data;
    logic        write_enable;
    logic        cpu_reset_n;
    logic        load_done;
    logic        load_error;
    logic [15:0] byte_count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_a[$];
    logic [7:0]  exp_d[$];
    logic [7:0]  pl[$];

    program_loader #(
        .BASE_ADDR(BASE),
        .MAX_BYTES(MAX),
        .TIMEOUT_CYCLES(32'(TMO)),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .rx_valid(rx_valid),
        .rx_data(rx_data),
        .rx_ready(rx_ready),
        .write_address(write_address),
        .write_data(write_data),
        .write_enable(write_enable),
        .cpu_reset_n(cpu_reset_n),
        .load_done(load_done),
        .load_error(load_error),
        .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (reset_n && write_enable) begin
            if (exp_a.size() == 0) begin
                check("unexpected_write", 32'(write_enable), 32'd0);
            end else begin
                check("write_addr", write_address, exp_a.pop_front());
                check("write_data", 32'(write_data), 32'(exp_d.pop_front()));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1);
    end

    task automatic do_reset();
        rx_valid = 1'b0;
        reset_n  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int n;
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!rx_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!rx_ready) check("rx_ready_wait", 32'(rx_ready), 32'd1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        repeat ($urandom_range(max_gap, 0)) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [7:0] payload_sum();
        int s = 0;
        foreach (pl[i]) s = (s + int'(pl[i])) % 256;
        return 8'(s);
    endfunction

    task automatic fill_random(input int len);
        pl.delete();
        for (int i = 0; i < len; i++) pl.push_back(8'($urandom_range(255, 0)));
    endtask

    // Sends sync, length, the payload in pl and csum; the frame model
    // decides the outcome from the length rule and the payload sum.
    task automatic run_frame(input int len, input logic [7:0] csum, input int max_gap, input string tag);
        bit len_bad;
        bit exp_ok;
        len_bad = (len == 0) || (len > MAX);
        send_byte(8'hA5, max_gap);
        send_byte(8'(len), max_gap);
        send_byte(8'(len >> 8), max_gap);
        if (len_bad) begin
            check({tag, "_len_error"}, 32'(load_error), 32'd1);
            check({tag, "_len_count"}, 32'(byte_count), 32'd0);
            check({tag, "_len_rdy"}, 32'(rx_ready), 32'd1);
        end else begin
            for (int i = 0; i < len; i++) begin
                exp_a.push_back(BASE + 32'(i));
                exp_d.push_back(pl[i]);
                send_byte(pl[i], max_gap);
            end
            exp_ok = (csum == payload_sum());
            send_byte(csum, 0);
            check({tag, "_done"}, 32'(load_done), 32'(exp_ok));
            check({tag, "_error"}, 32'(load_error), 32'(!exp_ok));
            check({tag, "_cpu_rst_n"}, 32'(cpu_reset_n), 32'(exp_ok));
            check({tag, "_rx_ready"}, 32'(rx_ready), 32'(!exp_ok));
            check({tag, "_byte_count"}, 32'(byte_count), 32'(len));
        end
        check({tag, "_writes_left"}, 32'(exp_a.size()), 32'd0);
    endtask

    task automatic good_payload();
        pl.delete();
        pl.push_back(8'h13);
        pl.push_back(8'h00);
        pl.push_back(8'h00);
        pl.push_back(8'h00);
    endtask

    initial begin
        int n;
        int len;
        logic [7:0] cs;

        // Outputs while held in reset.
        repeat (2) @(posedge clk);
        #1;
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
        check("rst_load_done", 32'(load_done), 32'd0);
        check("rst_load_error", 32'(load_error), 32'd0);
        check("rst_write_enable", 32'(write_enable), 32'd0);
        check("rst_byte_count", 32'(byte_count), 32'd0);
        do_reset();
        check("idle_rx_ready", 32'(rx_ready), 32'd1);

        // Good frame.
        good_payload();
        run_frame(4, 8'h13, 0, "good");

        // Bad checksum, then retry from the error state.
        do_reset();
        good_payload();
        run_frame(4, 8'h14, 0, "badcs");
        run_frame(4, 8'h13, 0, "retry");

        // Length above the limit, length zero, length exactly at the limit.
        do_reset();
        pl.delete();
        run_frame(1025, 8'h00, 0, "len1025");
        run_frame(0, 8'h00, 0, "len0");
        fill_random(MAX);
        run_frame(MAX, payload_sum(), 0, "lenmax");

        // Junk before sync.
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'hFF, 0);
        send_byte(8'h5A, 0);
        check("junk_error", 32'(load_error), 32'd0);
        good_payload();
        run_frame(4, 8'h13, 1, "junk");

        // No timeout in IDLE; timeout after the length low byte.
        do_reset();
        repeat (3 * TMO) @(posedge clk);
        #1;
        check("idle_no_timeout", 32'(load_error), 32'd0);
        send_byte(8'hA5, 0);
        send_byte(8'h04, 0);
        n = 0;
        while (!load_error && n < 4 * TMO) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("timeout_cycles", 32'(n), 32'(TMO));
        check("timeout_cpu_rst_n", 32'(cpu_reset_n), 32'd0);

        // Reset in the middle of the payload.
        do_reset();
        send_byte(8'hA5, 0);
        send_byte(8'h04, 0);
        send_byte(8'h00, 0);
        exp_a.push_back(BASE);
        exp_d.push_back(8'h13);
        send_byte(8'h13, 0);
        exp_a.push_back(BASE + 32'd1);
        exp_d.push_back(8'h00);
        send_byte(8'h00, 0);
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("midrst_write_enable", 32'(write_enable), 32'd0);
        check("midrst_addr", write_address, 32'd0);
        check("midrst_rx_ready", 32'(rx_ready), 32'd0);
        check("midrst_byte_count", 32'(byte_count), 32'd0);
        check("midrst_writes_left", 32'(exp_a.size()), 32'd0);
        #20;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        good_payload();
        run_frame(4, 8'h13, 3, "afterrst");

        // Random frames with random gaps, some with corrupted checksums.
        for (int k = 0; k < 8; k++) begin
            do_reset();
            len = $urandom_range(24, 1);
            fill_random(len);
            cs = payload_sum();
            if ($urandom_range(2, 0) == 0) cs = cs + 8'($urandom_range(255, 1));
            run_frame(len, cs, 3, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
